rr_arb_encode: RTL
==================

Name: rr_arb_encode

Overview:
- Round-robin arbiter that selects one of CNT requesters and drives the encoded select and valid into the downstream encoded word mux.
- Sits directly upstream of the encoded word mux in the xregs datapath. Its grant_sel drives the mux select.
- Supports multi-beat transfers: a grant is held until the owning requester's last beat is accepted.
- Registered outputs with a valid/ready handshake toward the consumer.

Parameters:
- CNT, 5, number of requesters.
- CNT_WIDTH, 3, width of the encoded select; must satisfy 2^CNT_WIDTH >= CNT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  CNT  per-requester request level; held by the requester until acked.
- req_last  input  CNT  per-requester "current beat is last" flag; sampled only for the granted index.
- out_ready  input  1  consumer accepts the current beat.
- grant_vld  output  1  a grant is active; the mux output is a valid beat.
- grant_sel  output  CNT_WIDTH  encoded index of the granted requester.
- grant_oh  output  CNT  one-hot form of grant_sel; all zero when grant_vld=0.
- req_ack  output  CNT  one-cycle pulse to the granted requester when its last beat is accepted.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, pointer=0, grant_vld=0, grant_sel=0, grant_oh=0, req_ack=0.
- The pointer is an internal register (CNT_WIDTH bits) holding the highest-priority index.
- Winner search: the first i with req[i]=1, scanning pointer, pointer+1, …, CNT-1, 0, …, pointer-1.
  - Wrap is at CNT, not at 2^CNT_WIDTH.
  - Indices >= CNT are never produced.
- State IDLE:
  - grant_vld=0.
  - If any req bit is set: register the winner into grant_sel/grant_oh, go to GRANT, and drive grant_vld=1 in the next cycle.
  - Latency is 1 cycle from req to grant_vld.
- State GRANT:
  - grant_vld=1; grant_sel and grant_oh are held stable.
  - Handshake = grant_vld & out_ready.
  - Handshake with req_last[grant_sel]=0: stay in GRANT (next beat).
  - Handshake with req_last[grant_sel]=1:
    - req_ack[grant_sel] pulses high next cycle for one cycle.
    - pointer <= (grant_sel==CNT-1) ? 0 : grant_sel+1.
    - state <= IDLE; grant_vld=0 next cycle.
  - No handshake: hold all outputs. The grant is not preempted by other requesters.
  - Cancel: req[grant_sel]=0 and no handshake in a cycle -> go to IDLE next cycle. Pointer unchanged, no req_ack.
  - Handshake takes priority over cancel if both occur in the same cycle.
- After release there is a mandatory 1-cycle IDLE gap before the next grant.
- req changes on non-granted indices during GRANT have no effect.
- A requester must drop req in the cycle it sees req_ack. Otherwise it is re-arbitrated as a new request at the lowest priority under the updated pointer.
- grant_oh[i]=1 exactly when grant_vld=1 and grant_sel==i.
- req_ack is at most one-hot.
- Reset mid-transfer: outputs return to reset values immediately (asynchronously). The pointer returns to 0 and no req_ack is issued.
- All outputs are driven from flops; there is no combinational path from req or out_ready to any output.

Test Plan:
- Single requester, CNT=5:
  - Stimulus: req=5'b00100, req_last=1, out_ready=1.
  - Required: grant_vld rises 1 cycle later with grant_sel=2, grant_oh=5'b00100; req_ack[2] pulses the cycle after the handshake; pointer=3.
- Round-robin fairness:
  - Stimulus: req=5'b11111 held; each requester drops req after its req_ack; single-beat transfers; out_ready=1.
  - Required: grant_sel sequence 0,1,2,3,4 with one IDLE cycle between grants.
- Wrap at CNT:
  - Stimulus: pointer=4 (after granting 3); req=5'b10001.
  - Required: grant_sel=4 first; after its ack the pointer is 0 and the next grant is 0. grant_sel never reaches 5–7.
- Multi-beat with backpressure:
  - Stimulus: requester 1 sends 3 beats (req_last on beat 3); out_ready toggles 1,0,1,0,1; req[3] is also asserted.
  - Required: grant_sel stays 1 for all 3 beats; req_ack[1] appears only after the third accepted beat; requester 3 is granted next.
- Cancel:
  - Stimulus: grant to requester 2; req[2] drops with out_ready=0.
  - Required: grant_vld=0 next cycle, no req_ack, pointer stays at its prior value.
  - Then with req=5'b00100 re-asserted: grant_sel=2 again.
- Asynchronous reset mid-transfer:
  - Stimulus: assert rst mid-cycle while grant_vld=1, grant_sel=3.
  - Required: grant_vld, grant_oh and req_ack go to 0 before the next clock edge; after release with req=5'b01000 the grant goes to 3, with the pointer having restarted at 0.

Source files
------------

// File: rtl/rr_arb_encode.sv
// Round-robin arbiter with multi-beat grant hold, driving the encoded select
// and one-hot grant of the downstream encoded word mux. All outputs are flops.
module rr_arb_encode #(
  parameter int CNT       = 5,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT-1:0]       req,
  input  logic [CNT-1:0]       req_last,
  input  logic                 out_ready,
  output logic                 grant_vld,
  output logic [CNT_WIDTH-1:0] grant_sel,
  output logic [CNT-1:0]       grant_oh,
  output logic [CNT-1:0]       req_ack
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0] grant_sel_reg, grant_sel_next;
  logic                 grant_vld_reg, grant_vld_next;
  logic [CNT-1:0]       grant_oh_reg, grant_oh_next;
  logic [CNT-1:0]       req_ack_reg, req_ack_next;

  logic [CNT_WIDTH-1:0] cand_idx [CNT];
  logic [CNT-1:0]       cand_req;
  logic                 win_found;
  logic [CNT_WIDTH-1:0] win_idx;
  logic                 hs;
  logic                 owner_last;
  logic                 owner_req;

  // Candidate gi is the requester at priority rank gi: (ptr + gi) wrapped at CNT.
  genvar gi;
  generate
    for (gi = 0; gi < CNT; gi++) begin : g_cand
      logic [CNT_WIDTH:0] sum;
      assign sum = {1'b0, ptr_reg} + (CNT_WIDTH+1)'(gi);
      assign cand_idx[gi] = (sum >= (CNT_WIDTH+1)'(CNT)) ?
                            CNT_WIDTH'(sum - (CNT_WIDTH+1)'(CNT)) :
                            sum[CNT_WIDTH-1:0];
      assign cand_req[gi] = |(req & (CNT'(1) << cand_idx[gi]));
    end
  endgenerate

  // Scan from lowest rank upward; the last write is the highest-priority hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = CNT - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // The one-hot grant masks req/req_last down to the owner without indexing.
  assign hs         = grant_vld_reg & out_ready;
  assign owner_last = |(req_last & grant_oh_reg);
  assign owner_req  = |(req & grant_oh_reg);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_sel_next = grant_sel_reg;
    grant_vld_next = grant_vld_reg;
    grant_oh_next  = grant_oh_reg;
    req_ack_next   = '0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next     = GRANT;
          grant_sel_next = win_idx;
          grant_oh_next  = CNT'(1) << win_idx;
          grant_vld_next = 1'b1;
        end
      end
      GRANT: begin
        if (hs) begin
          if (owner_last) begin
            req_ack_next   = grant_oh_reg;
            ptr_next       = (grant_sel_reg == CNT_WIDTH'(CNT - 1)) ?
                             '0 : grant_sel_reg + 1'b1;
            state_next     = IDLE;
            grant_vld_next = 1'b0;
            grant_oh_next  = '0;
          end
        end else if (!owner_req) begin
          // Owner withdrew before finishing: release without ack or pointer move.
          state_next     = IDLE;
          grant_vld_next = 1'b0;
          grant_oh_next  = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        grant_vld_next = 1'b0;
        grant_oh_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      grant_sel_reg <= '0;
      grant_vld_reg <= 1'b0;
      grant_oh_reg  <= '0;
      req_ack_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_sel_reg <= grant_sel_next;
      grant_vld_reg <= grant_vld_next;
      grant_oh_reg  <= grant_oh_next;
      req_ack_reg   <= req_ack_next;
    end
  end

  assign grant_vld = grant_vld_reg;
  assign grant_sel = grant_sel_reg;
  assign grant_oh  = grant_oh_reg;
  assign req_ack   = req_ack_reg;

endmodule
